// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Load/store alignment unit. Aligned accesses go to DMEM in one beat;
//           misaligned half/word accesses are split into byte beats.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align #(
    parameter int WIDTH_ADDR_LENGTH = 32,
    parameter int WIDTH_DATA_LENGTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Req,
    input  logic [WIDTH_ADDR_LENGTH-1:0] Addr,
    input  logic [WIDTH_DATA_LENGTH-1:0] DataW,
    input  logic                         MemRW,
    input  logic [1:0]                   LenSel,
    input  logic                         LoadUnsigned,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Err,
    output logic [WIDTH_DATA_LENGTH-1:0] DataR,
    output logic [WIDTH_ADDR_LENGTH-1:0] MemAddr,
    output logic [WIDTH_DATA_LENGTH-1:0] MemDataW,
    output logic                         MemWE,
    output logic [1:0]                   MemLenSel,
    input  logic [WIDTH_DATA_LENGTH-1:0] MemDataR
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_SPLIT  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]                   r_state;
    logic [WIDTH_ADDR_LENGTH-1:0] r_addr;
    logic [WIDTH_DATA_LENGTH-1:0] r_dataW;
    logic                         r_memRW;
    logic [1:0]                   r_lenSel;
    logic                         r_loadUnsigned;
    logic [1:0]                   r_beat;
    logic [WIDTH_DATA_LENGTH-1:0] r_asm;

    logic                         w_aligned;
    logic [1:0]                   w_nextBeat;
    logic [1:0]                   w_lastBeat;
    logic [WIDTH_DATA_LENGTH-1:0] w_asmNext;

    function automatic logic [WIDTH_DATA_LENGTH-1:0] extendLoad(
        input logic [WIDTH_DATA_LENGTH-1:0] raw,
        input logic [1:0]                   len,
        input logic                         uns
    );
        logic [WIDTH_DATA_LENGTH-1:0] v;
        case (len)
            2'b00:   v = uns ? {{(WIDTH_DATA_LENGTH-8){1'b0}}, raw[7:0]}
                         : {{(WIDTH_DATA_LENGTH-8){raw[7]}}, raw[7:0]};
            2'b01:   v = uns ? {{(WIDTH_DATA_LENGTH-16){1'b0}}, raw[15:0]}
                         : {{(WIDTH_DATA_LENGTH-16){raw[15]}}, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    always_comb begin
        case (LenSel)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~Addr[0];
            2'b10:   w_aligned = (Addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_nextBeat = r_beat + 2'd1;
    assign w_lastBeat = (r_lenSel == 2'b01) ? 2'd1 : 2'd3;

    // Little-endian reassembly: beat k lands in byte lane k.
    always_comb begin
        w_asmNext = r_asm;
        w_asmNext[{r_beat, 3'b000} +: 8] = MemDataR[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_addr         <= '0;
            r_dataW        <= '0;
            r_memRW        <= 1'b0;
            r_lenSel       <= 2'b00;
            r_loadUnsigned <= 1'b0;
            r_beat         <= 2'd0;
            r_asm          <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            Err            <= 1'b0;
            DataR          <= '0;
            MemAddr        <= '0;
            MemDataW       <= '0;
            MemWE          <= 1'b0;
            MemLenSel      <= 2'b00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Req) begin
                        r_addr         <= Addr;
                        r_dataW        <= DataW;
                        r_memRW        <= MemRW;
                        r_lenSel       <= LenSel;
                        r_loadUnsigned <= LoadUnsigned;
                        r_beat         <= 2'd0;
                        r_asm          <= '0;
                        Busy           <= 1'b1;
                        if (LenSel == 2'b11) begin
                            r_state <= c_DONE;
                            Done    <= 1'b1;
                            Err     <= 1'b1;
                            DataR   <= '0;
                        end else if (w_aligned) begin
                            r_state   <= c_ACCESS;
                            MemAddr   <= Addr;
                            MemLenSel <= LenSel;
                            MemDataW  <= DataW;
                            MemWE     <= MemRW;
                        end else begin
                            r_state   <= c_SPLIT;
                            MemAddr   <= Addr;
                            MemLenSel <= 2'b00;
                            MemDataW  <= {{(WIDTH_DATA_LENGTH-8){1'b0}}, DataW[7:0]};
                            MemWE     <= MemRW;
                        end
                    end
                end
                c_ACCESS: begin
                    r_asm   <= MemDataR;
                    r_state <= c_DONE;
                    MemWE   <= 1'b0;
                    Done    <= 1'b1;
                    Err     <= 1'b0;
                    DataR   <= r_memRW ? '0 : extendLoad(MemDataR, r_lenSel, r_loadUnsigned);
                end
                c_SPLIT: begin
                    r_asm <= w_asmNext;
                    if (r_beat == w_lastBeat) begin
                        r_state <= c_DONE;
                        MemWE   <= 1'b0;
                        Done    <= 1'b1;
                        Err     <= 1'b0;
                        DataR   <= r_memRW ? '0 : extendLoad(w_asmNext, r_lenSel, r_loadUnsigned);
                    end else begin
                        r_beat   <= w_nextBeat;
                        // Address arithmetic wraps naturally at the top of the space.
                        MemAddr  <= r_addr + {{(WIDTH_ADDR_LENGTH-2){1'b0}}, w_nextBeat};
                        MemDataW <= {{(WIDTH_DATA_LENGTH-8){1'b0}}, r_dataW[{w_nextBeat, 3'b000} +: 8]};
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    Err     <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_align
// Brief   : Randomized scoreboard bench for lsu_align with a byte-array DMEM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Req = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] DataW = '0;
    logic        MemRW = 1'b0;
    logic [1:0]  LenSel = 2'b00;
    logic        LoadUnsigned = 1'b0;
    logic        Busy, Done, Err;
    logic [31:0] DataR, MemAddr, MemDataW;
    logic        MemWE;
    logic [1:0]  MemLenSel;
    logic [31:0] MemDataR;

    lsu_align #(.WIDTH_ADDR_LENGTH(32), .WIDTH_DATA_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .Req(Req), .Addr(Addr), .DataW(DataW), .MemRW(MemRW),
        .LenSel(LenSel), .LoadUnsigned(LoadUnsigned), .Busy(Busy), .Done(Done), .Err(Err),
        .DataR(DataR), .MemAddr(MemAddr), .MemDataW(MemDataW), .MemWE(MemWE),
        .MemLenSel(MemLenSel), .MemDataR(MemDataR)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // DMEM: combinational read, writes ignored while the system is in reset.
    logic [7:0] dmem [logic [31:0]];
    int memVer = 0;

    function automatic logic [7:0] dmemByte(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : dflt(a);
    endfunction

    always @(MemAddr or MemLenSel or memVer) begin
        case (MemLenSel)
            2'b00:   MemDataR = {24'h0, dmemByte(MemAddr)};
            2'b01:   MemDataR = {16'h0, dmemByte(MemAddr + 32'd1), dmemByte(MemAddr)};
            default: MemDataR = {dmemByte(MemAddr + 32'd3), dmemByte(MemAddr + 32'd2),
                                 dmemByte(MemAddr + 32'd1), dmemByte(MemAddr)};
        endcase
    end

    always @(posedge clk) begin
        if (!rst && MemWE) begin
            for (int i = 0; i < ((MemLenSel == 2'b00) ? 1 : (MemLenSel == 2'b01) ? 2 : 4); i++)
                dmem[MemAddr + 32'(i)] = MemDataW[8*i +: 8];
            memVer <= memVer + 1;
        end
    end

    // Golden byte-addressed memory, updated when a store is issued.
    logic [7:0] gold [logic [31:0]];

    function automatic logic [7:0] goldByte(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] len, input bit uns);
        logic [31:0] v;
        v = {goldByte(a + 32'd3), goldByte(a + 32'd2), goldByte(a + 32'd1), goldByte(a)};
        if (len == 2'b00) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (len == 2'b01) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    typedef struct {
        logic [31:0] data;
        bit          err;
        int          lat;
        bit          store;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  d;
        logic [1:0]  len;
    } beat_t;

    exp_t  sb[$];
    beat_t beatLog[$];
    exp_t  monE;
    int    busyCnt = 0;
    bit    sawWe = 1'b0;

    // Monitor: counts busy cycles and write beats, pops the scoreboard on Done.
    always @(negedge clk) begin
        if (rst) begin
            busyCnt = 0;
            sawWe = 1'b0;
        end else begin
            if (Busy) busyCnt++;
            if (MemWE) begin
                sawWe = 1'b1;
                beatLog.push_back('{addr: MemAddr, d: MemDataW[7:0], len: MemLenSel});
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected Done", 32'd1, 32'd0);
                end else begin
                    monE = sb.pop_front();
                    chk({"DataR ", monE.name}, DataR, monE.data);
                    chk({"Err ", monE.name}, {31'd0, Err}, {31'd0, monE.err});
                    chk({"latency ", monE.name}, 32'(busyCnt), 32'(monE.lat));
                    chk({"MemWE seen ", monE.name}, {31'd0, sawWe}, {31'd0, monE.store});
                end
                busyCnt = 0;
                sawWe = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit rw,
                         input logic [1:0] len, input bit uns, input bit noisy, input string nm);
        exp_t e;
        int   n;
        e.err   = (len == 2'b11);
        e.store = rw && !e.err;
        e.data  = (rw || e.err) ? 32'h0 : refLoad(a, len, uns);
        e.name  = nm;
        case (len)
            2'b00:   e.lat = 2;
            2'b01:   e.lat = a[0] ? 3 : 2;
            2'b10:   e.lat = (a[1:0] == 2'b00) ? 2 : 5;
            default: e.lat = 1;
        endcase
        sb.push_back(e);
        if (e.store)
            for (int i = 0; i < ((len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4); i++)
                gold[a + 32'(i)] = d[8*i +: 8];

        Req = 1'b1; Addr = a; DataW = d; MemRW = rw; LenSel = len; LoadUnsigned = uns;
        n = 0;
        while (Busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        while (Busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        while (Done !== 1'b1 && n < 40) begin
            if (noisy) begin
                Addr = $urandom; DataW = $urandom; MemRW = 1'($urandom);
            end else begin
                Req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk({"timeout ", nm}, 32'(n), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  len;
        int          r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset Busy", {31'd0, Busy}, 32'd0);
        chk("reset Done", {31'd0, Done}, 32'd0);
        chk("reset Err", {31'd0, Err}, 32'd0);
        chk("reset DataR", DataR, 32'd0);
        chk("reset MemAddr", MemAddr, 32'd0);
        chk("reset MemDataW", MemDataW, 32'd0);
        chk("reset MemWE", {31'd0, MemWE}, 32'd0);
        chk("reset MemLenSel", {30'd0, MemLenSel}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        beatLog.delete();
        issue(32'h0, 32'h1234_5678, 1, 2'b10, 0, 0, "aligned word store");
        chk("aligned store beats", 32'(beatLog.size()), 32'd1);
        if (beatLog.size() == 1) begin
            chk("aligned store addr", beatLog[0].addr, 32'h0);
            chk("aligned store len", {30'd0, beatLog[0].len}, 32'd2);
            chk("aligned store byte0", {24'd0, beatLog[0].d}, 32'h78);
        end
        issue(32'h0, 32'h0, 0, 2'b10, 0, 0, "aligned word load");

        beatLog.delete();
        issue(32'h5, 32'hA1B2_C3D4, 1, 2'b10, 0, 0, "split word store");
        chk("split store beats", 32'(beatLog.size()), 32'd4);
        if (beatLog.size() == 4) begin
            chk("split beat0", {beatLog[0].addr[23:0], beatLog[0].d}, 32'h0000_05D4);
            chk("split beat1", {beatLog[1].addr[23:0], beatLog[1].d}, 32'h0000_06C3);
            chk("split beat2", {beatLog[2].addr[23:0], beatLog[2].d}, 32'h0000_07B2);
            chk("split beat3", {beatLog[3].addr[23:0], beatLog[3].d}, 32'h0000_08A1);
            chk("split beat len", {30'd0, beatLog[3].len}, 32'd0);
        end
        issue(32'h5, 32'h0, 0, 2'b10, 0, 0, "split word load");

        issue(32'h10, 32'hFFFF_FF80, 1, 2'b00, 0, 0, "byte store 0x80");
        issue(32'h10, 32'h0, 0, 2'b00, 0, 0, "signed byte load");
        issue(32'h10, 32'h0, 0, 2'b00, 1, 0, "unsigned byte load");
        issue(32'hF, 32'h0000_0034, 1, 2'b00, 0, 0, "byte store 0x34");
        issue(32'hF, 32'h0, 0, 2'b01, 0, 0, "signed split half load");
        issue(32'hF, 32'h0, 0, 2'b01, 1, 0, "unsigned split half load");
        issue(32'h40, 32'h0, 0, 2'b11, 0, 0, "illegal load");
        issue(32'h41, 32'hDEAD_BEEF, 1, 2'b11, 0, 0, "illegal store");

        // Abort a split store after its first beat.
        @(negedge clk);
        Req = 1'b1; Addr = 32'h21; DataW = 32'h1122_3344; MemRW = 1'b1; LenSel = 2'b10; LoadUnsigned = 1'b0;
        @(negedge clk);
        Req = 1'b0;
        chk("abort Busy in beat0", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        chk("abort beat1 addr", MemAddr, 32'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort Busy", {31'd0, Busy}, 32'd0);
        chk("abort Done", {31'd0, Done}, 32'd0);
        chk("abort MemWE", {31'd0, MemWE}, 32'd0);
        gold[32'h21] = 8'h44;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            issue(32'h21 + 32'(i), 32'h0, 0, 2'b00, 1, 0, "post-abort byte load");

        beatLog.delete();
        issue(32'hFFFF_FFFE, 32'hCAFE_F00D, 1, 2'b10, 0, 0, "wrap word store");
        if (beatLog.size() == 4) begin
            chk("wrap beat2 addr", beatLog[2].addr, 32'h0);
            chk("wrap beat3 addr", beatLog[3].addr, 32'h1);
        end else begin
            chk("wrap store beats", 32'(beatLog.size()), 32'd4);
        end
        issue(32'hFFFF_FFFE, 32'h0, 0, 2'b10, 0, 0, "wrap word load");
        issue(32'h0, 32'h0, 0, 2'b01, 1, 0, "wrapped half load");

        for (int t = 0; t < 80; t++) begin
            a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                            : 32'h100 + 32'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            len = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            issue(a, $urandom, 1'($urandom), len, 1'($urandom), 1'($urandom), "random");
        end
        Req = 1'b0;

        repeat (6) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit between the core's MEM stage and the data memory (DMEM).
- Naturally aligned accesses are issued as a single DMEM transaction.
- Misaligned halfword/word accesses are split into sequential byte transactions, and load data is reassembled.
- Returns sign- or zero-extended load data and stalls the pipeline via Busy while a request is in flight.

Parameters:
- WIDTH_ADDR_LENGTH, 32, byte-address width.
- WIDTH_DATA_LENGTH, 32, data width; fixed at 32 for this block.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Req  in  1  request valid; sampled only in IDLE
- Addr  in  WIDTH_ADDR_LENGTH  byte address of access
- DataW  in  32  store data, right-justified
- MemRW  in  1  1 = store, 0 = load
- LenSel  in  2  00 byte, 01 half, 10 word, 11 illegal
- LoadUnsigned  in  1  1 = zero-extend load, 0 = sign-extend
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle completion pulse
- Err  out  1  valid with Done; 1 = illegal LenSel
- DataR  out  32  extended load data; valid while Done=1
- MemAddr  out  WIDTH_ADDR_LENGTH  DMEM address
- MemDataW  out  32  DMEM write data
- MemWE  out  1  DMEM write enable (DMEM MemRW)
- MemLenSel  out  2  DMEM length select
- MemDataR  in  32  DMEM read data; combinational from MemAddr, right-justified

Behaviour:
- Reset: state=IDLE; Busy, Done, Err, MemWE = 0; DataR, MemAddr, MemDataW, MemLenSel = 0; request and assembly registers cleared.
- Reset mid-operation aborts the access and produces no Done. Store bytes already written stay written.
- Accept: in IDLE with Req=1, register Addr, DataW, MemRW, LenSel and LoadUnsigned. Input changes after acceptance are ignored.
- Alignment test: a byte is always aligned; a half is aligned when Addr[0]=0; a word is aligned when Addr[1:0]=0.
- FSM states: IDLE, ACCESS, SPLIT, DONE.
  - IDLE -> DONE (Err=1) if LenSel=11. No DMEM access.
  - IDLE -> ACCESS if the access is aligned.
  - IDLE -> SPLIT if it is misaligned; beat counter k=0 and N = 2 (half) or 4 (word).
  - ACCESS, one cycle:
    - MemAddr = Addr, MemLenSel = LenSel, MemDataW = DataW, MemWE = MemRW.
    - Load captures MemDataR at the clock edge.
    - Next state DONE.
  - SPLIT, beat k, one cycle per beat:
    - MemAddr = Addr + k (mod 2^WIDTH_ADDR_LENGTH), MemLenSel = 00.
    - MemDataW[7:0] = DataW[8k+7:8k]; upper bits 0.
    - MemWE = MemRW.
    - Load captures MemDataR[7:0] into assembly byte k (little-endian).
    - After k = N-1, go to DONE.
  - DONE, one cycle: Done=1 and DataR valid. Next state IDLE. Req in DONE is ignored.
- MemWE = 0 in IDLE and DONE. DMEM outputs hold their last values outside access cycles.
- DataR extension:
  - Byte: bit 7 is replicated, or zeros if LoadUnsigned.
  - Half: bit 15 is replicated, or zeros if LoadUnsigned.
  - Word: passed through.
  - Store or Err: DataR = 0.
- Latency from Req accepted at edge T:
  - Aligned access: Done at cycle T+2.
  - Misaligned half: Done at T+3.
  - Misaligned word: Done at T+5.
  - Illegal LenSel: Done at T+1.
- Throughput: a new Req is accepted at the earliest in the cycle after DONE (IDLE).
- Address wrap: a split beat crossing 0xFFFF_FFFF wraps to 0x0000_0000. No error is raised.

Test Plan:
- Aligned word store Addr=0x00, DataW=0x12345678, then load word Addr=0x00 -> single beat with MemWE=1, MemLenSel=10; load Done at T+2 with DataR=0x12345678, Err=0.
- Misaligned word store Addr=0x05, DataW=0xA1B2C3D4 -> 4 beats at MemAddr 0x05..0x08 with MemDataW[7:0] = D4, C3, B2, A1; a word load from 0x05 then returns 0xA1B2C3D4 at T+5, with Busy high for 5 cycles.
- Byte 0x80 at Addr 0x10: signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080. Misaligned half load at 0x0F, with bytes 0x0F=0x34 and 0x10=0x80 -> 0xFFFF8034 signed, 0x00008034 unsigned; Done at T+3.
- LenSel=11 with Req -> Done at T+1, Err=1, DataR=0, MemWE never asserted.
- Assert rst during beat k=1 of a misaligned word store to 0x21 -> next cycle state IDLE, Busy=0, no Done; byte 0x21 is written, bytes 0x22..0x24 are unchanged.
- Req held high continuously with changing Addr during a split access -> only the first request is processed; the next request is accepted in IDLE after DONE; Done pulses exactly once per request.
